div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 95 +++++++++
 tb/tb_div_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Iterative 32-bit signed/unsigned divider controller (restoring radix-2, one quotient bit per cycle).
// Latency: div_done 34 cycles after acceptance (1 cycle for a zero divisor when DIV0_FAST=1); flush/reset abort.
module div_ctrl #(
    parameter bit DIV0_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] div_x,
    input  logic [31:0] div_y,
    input  logic        flush,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_result,
    output logic [31:0] mod_result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, abs_y;
    logic        sign_q, sign_r;

    logic        sx, sy, accept, fast_zero;
    logic [31:0] abs_x_in, abs_y_in;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] rem_step, quo_step;

    assign sx        = div_signed & div_x[31];
    assign sy        = div_signed & div_y[31];
    assign abs_x_in  = sx ? (~div_x + 32'd1) : div_x;
    assign abs_y_in  = sy ? (~div_y + 32'd1) : div_y;
    assign accept    = (state == IDLE) && div_req && !flush;
    assign fast_zero = DIV0_FAST && (div_y == 32'd0);

    // Shift the next dividend bit into the partial remainder; 33 bits because it can reach 2*|y|.
    assign trial    = {rem, quo[31]};
    assign ge       = (trial >= {1'b0, abs_y});
    assign rem_step = ge ? (trial[31:0] - abs_y) : trial[31:0];
    assign quo_step = {quo[30:0], ge};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (div_req) state_nxt = fast_zero ? DONE : CALC;
            CALC: if (cnt == 5'd31) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            rem        <= 32'd0;
            quo        <= 32'd0;
            abs_y      <= 32'd0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div_result <= 32'd0;
            mod_result <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem    <= 32'd0;
                quo    <= abs_x_in;
                abs_y  <= abs_y_in;
                sign_q <= sx ^ sy;
                sign_r <= sx;
                cnt    <= 5'd0;
                if (fast_zero) begin
                    div_result <= 32'd0;
                    mod_result <= div_x;
                end
            end else if (state == CALC) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + 5'd1;
            end else if (state == FIX && !flush) begin
                div_result <= sign_q ? (~quo + 32'd1) : quo;
                mod_result <= sign_r ? (~rem + 32'd1) : rem;
            end
        end
    end

    assign div_busy = (state != IDLE);
    assign div_done = (state == DONE) && !flush;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl against an arithmetic reference model, plus flush/reset/latency corner cases.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset, div_req, div_signed, flush;
    logic [31:0] div_x, div_y;
    logic        div_busy, div_done;
    logic [31:0] div_result, mod_result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] prev_q = 32'd0;
    logic [31:0] prev_r = 32'd0;

    div_ctrl #(.DIV0_FAST(1'b1)) dut (
        .clk(clk), .reset(reset), .div_req(div_req), .div_signed(div_signed),
        .div_x(div_x), .div_y(div_y), .flush(flush), .div_busy(div_busy),
        .div_done(div_done), .div_result(div_result), .mod_result(mod_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncating division, remainder follows dividend; zero divisor gives q=0, r=x.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        if (y == 32'd0) begin
            q = 32'd0; r = x;
        end else if (!s) begin
            q = x / y; r = x % y;
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge with the DUT idle; returns one cycle after the DONE cycle.
    task automatic do_div(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] eq, er;
        int lat, n;
        bit seen;
        ref_div(x, y, s, eq, er);
        lat = (y == 32'd0) ? 1 : 34;
        div_x = x; div_y = y; div_signed = s; div_req = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (n == lat - 1) begin
                check({tag, "_hold_q"}, div_result, prev_q);
                check({tag, "_hold_r"}, mod_result, prev_r);
            end
            if (div_done) seen = 1;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_busy"}, {31'd0, div_busy}, 32'd1);
        check({tag, "_q"}, div_result, eq);
        check({tag, "_r"}, mod_result, er);
        tick();
        div_req = 1'b0;
        check({tag, "_idle"}, {30'd0, div_busy, div_done}, 32'd0);
        check({tag, "_stay_q"}, div_result, eq);
        prev_q = eq; prev_r = er;
    endtask

    initial begin
        logic [31:0] x, y;
        bit gotdone;
        reset = 1'b1; div_req = 1'b0; div_signed = 1'b0; flush = 1'b0;
        div_x = 32'd0; div_y = 32'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_done", {31'd0, div_done}, 32'd0);
        check("rst_q", div_result, 32'd0);
        check("rst_r", mod_result, 32'd0);

        do_div("u100_7", 32'd100, 32'd7, 1'b0);
        do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1);
        do_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1);
        do_div("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0);
        do_div("div0", 32'h1234, 32'd0, 1'b1);
        do_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1);

        // Flush and request on the same idle edge: flush wins.
        div_x = 32'd50; div_y = 32'd5; div_signed = 1'b0; div_req = 1'b1; flush = 1'b1;
        tick();
        check("flush_idle_busy", {31'd0, div_busy}, 32'd0);
        flush = 1'b0;
        do_div("after_fl", 32'd50, 32'd5, 1'b0);

        // Flush while iterating at counter 10 (11th cycle after acceptance).
        div_x = 32'd1000; div_y = 32'd3; div_signed = 1'b0; div_req = 1'b1;
        gotdone = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (div_done) gotdone = 1;
        end
        flush = 1'b1;
        if (div_done) gotdone = 1;
        tick();
        check("flush_nodone", {31'd0, gotdone}, 32'd0);
        check("flush_busy", {30'd0, div_busy, div_done}, 32'd0);
        check("flush_q", div_result, prev_q);
        check("flush_r", mod_result, prev_r);
        flush = 1'b0;
        do_div("post_fl", 32'hDEADBEEF, 32'd77, 1'b0);

        // Reset at counter 20.
        div_x = 32'd999; div_y = 32'd9; div_signed = 1'b1; div_req = 1'b1;
        gotdone = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (div_done) gotdone = 1;
        end
        reset = 1'b1; flush = 1'b1;
        tick();
        check("rst_mid_nodone", {31'd0, gotdone}, 32'd0);
        check("rst_mid_out", {30'd0, div_busy, div_done}, 32'd0);
        check("rst_mid_q", div_result, 32'd0);
        check("rst_mid_r", mod_result, 32'd0);
        reset = 1'b0; flush = 1'b0;
        prev_q = 32'd0; prev_r = 32'd0;
        do_div("b2b_a", 32'd12345, 32'd67, 1'b0);
        do_div("b2b_b", 32'hFFFF0000, 32'd300, 1'b1);

        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'd0;
                1: y = $urandom_range(1, 16);
                2: y = 32'($urandom) | 32'h80000000;
                default: y = $urandom;
            endcase
            do_div($sformatf("rnd%0d", i), x, y, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
